// File: rtl/cache_pkg.sv
// Shared definitions for the write-back cache controller and the datapath decoder.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  // cache_in_select encodings
  localparam logic CACHE_SEL_CPU = 1'b1;
  localparam logic CACHE_SEL_MEM = 1'b0;

  // mem_in_select encodings
  localparam logic MEM_SEL_VICTIM = 1'b1;
  localparam logic MEM_SEL_REQ    = 1'b0;

  // Opcodes the datapath decodes into req_valid / req_is_store
  localparam logic [5:0] OPC_LW = 6'h23;
  localparam logic [5:0] OPC_SW = 6'h2b;

  function automatic int beat_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cache_wb_ctrl_sat_counter.sv
// Saturating up-counter used for the controller's performance statistics.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst_b) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_wb_ctrl.sv
// Write-back cache controller: hit service, dirty writeback, per-beat refill, replay.
module cache_wb_ctrl
  import cache_pkg::*;
#(
  parameter int   WORDS_PER_BLOCK = 4,
  parameter int   CNT_W           = 32,
  localparam int  BEAT_W          = beat_width(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  input  logic              req_is_store,
  input  logic              hit,
  input  logic              dirty,
  input  logic              mem_ready,
  output logic              stall,
  output logic              reg_write_enable,
  output logic              cache_we,
  output logic              cache_in_select,
  output logic              mem_we,
  output logic              mem_re,
  output logic              mem_in_select,
  output logic [BEAT_W-1:0] beat_idx,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  wb_count
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);

  state_t            state;
  logic              replay;
  logic              last_beat;
  logic [BEAT_W-1:0] beat_inc;
  logic              lookup;
  logic              hit_inc;
  logic              miss_inc;
  logic              wb_inc;

  assign last_beat = (beat_idx == LAST_BEAT);
  // A single-word block keeps beat_idx pinned at 0.
  assign beat_inc  = (WORDS_PER_BLOCK == 1) ? '0 : beat_idx + BEAT_W'(1);

  assign lookup   = (state == IDLE) && req_valid;
  // The replayed access after COMMIT is not a new lookup; an aliasing miss still is.
  assign hit_inc  = lookup && hit && !replay;
  assign miss_inc = lookup && !hit;
  assign wb_inc   = miss_inc && dirty;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state    <= IDLE;
      beat_idx <= '0;
      replay   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            replay <= 1'b0;
            if (!hit) begin
              state    <= dirty ? WRITEBACK : REFILL;
              beat_idx <= '0;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            if (last_beat) begin
              state    <= REFILL;
              beat_idx <= '0;
            end else begin
              beat_idx <= beat_inc;
            end
          end
        end
        REFILL: begin
          if (mem_ready) begin
            beat_idx <= beat_inc;
            if (last_beat) begin
              state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          replay <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state    <= IDLE;
          beat_idx <= '0;
        end
      endcase
    end
  end

  always_comb begin
    stall            = 1'b0;
    reg_write_enable = 1'b0;
    cache_we         = 1'b0;
    cache_in_select  = CACHE_SEL_MEM;
    mem_we           = 1'b0;
    mem_re           = 1'b0;
    mem_in_select    = MEM_SEL_REQ;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (hit) begin
            reg_write_enable = !req_is_store;
            cache_we         = req_is_store;
            cache_in_select  = req_is_store ? CACHE_SEL_CPU : CACHE_SEL_MEM;
          end else begin
            stall = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        stall         = 1'b1;
        mem_we        = 1'b1;
        mem_in_select = MEM_SEL_VICTIM;
      end
      REFILL: begin
        stall           = 1'b1;
        mem_re          = 1'b1;
        mem_in_select   = MEM_SEL_REQ;
        cache_we        = mem_ready;
        cache_in_select = CACHE_SEL_MEM;
      end
      COMMIT: begin
        stall = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (miss_inc),
    .count (miss_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (wb_inc),
    .count (wb_count)
  );

endmodule

// File: tb/tb_cache_wb_ctrl.sv
// Bench for cache_wb_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_cache_wb_ctrl;

  localparam int WPB = 4;

  logic clk = 1'b0;
  logic rst_b;

  // main instance (4 words, 32-bit counters)
  logic        req_valid, req_is_store, hit, dirty, mem_ready;
  logic        stall, reg_write_enable, cache_we, cache_in_select;
  logic        mem_we, mem_re, mem_in_select;
  logic [1:0]  beat_idx;
  logic [31:0] hit_count, miss_count, wb_count;

  // saturation instance (4-bit counters)
  logic        s_req_valid, s_hit, s_zero;
  logic        s_stall, s_rwe, s_cwe, s_cis, s_mwe, s_mre, s_mis;
  logic [1:0]  s_beat;
  logic [3:0]  s_hit_count, s_miss_count, s_wb_count;

  // single-word-block instance
  logic        w_req_valid, w_is_store, w_hit, w_dirty, w_mem_ready;
  logic        w_stall, w_rwe, w_cwe, w_cis, w_mwe, w_mre, w_mis;
  logic [0:0]  w_beat;
  logic [31:0] w_hit_count, w_miss_count, w_wb_count;

  int vectors = 0;
  int miscompares = 0;

  int m_hits, m_misses, m_wbs;
  bit m_replay;
  bit tog;

  always #5 clk = ~clk;

  cache_wb_ctrl #(.WORDS_PER_BLOCK(WPB), .CNT_W(32)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_is_store(req_is_store),
    .hit(hit), .dirty(dirty), .mem_ready(mem_ready), .stall(stall),
    .reg_write_enable(reg_write_enable), .cache_we(cache_we), .cache_in_select(cache_in_select),
    .mem_we(mem_we), .mem_re(mem_re), .mem_in_select(mem_in_select), .beat_idx(beat_idx),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  cache_wb_ctrl #(.WORDS_PER_BLOCK(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_b(rst_b), .req_valid(s_req_valid), .req_is_store(s_zero),
    .hit(s_hit), .dirty(s_zero), .mem_ready(s_zero), .stall(s_stall),
    .reg_write_enable(s_rwe), .cache_we(s_cwe), .cache_in_select(s_cis),
    .mem_we(s_mwe), .mem_re(s_mre), .mem_in_select(s_mis), .beat_idx(s_beat),
    .hit_count(s_hit_count), .miss_count(s_miss_count), .wb_count(s_wb_count)
  );

  cache_wb_ctrl #(.WORDS_PER_BLOCK(1), .CNT_W(32)) dut_w1 (
    .clk(clk), .rst_b(rst_b), .req_valid(w_req_valid), .req_is_store(w_is_store),
    .hit(w_hit), .dirty(w_dirty), .mem_ready(w_mem_ready), .stall(w_stall),
    .reg_write_enable(w_rwe), .cache_we(w_cwe), .cache_in_select(w_cis),
    .mem_we(w_mwe), .mem_re(w_mre), .mem_in_select(w_mis), .beat_idx(w_beat),
    .hit_count(w_hit_count), .miss_count(w_miss_count), .wb_count(w_wb_count)
  );

  // {stall, reg_write_enable, cache_we, cache_in_select, mem_we, mem_re, mem_in_select, beat}
  function automatic logic [8:0] obs();
    return {stall, reg_write_enable, cache_we, cache_in_select, mem_we, mem_re, mem_in_select, beat_idx};
  endfunction

  function automatic logic [7:0] obs_w();
    return {w_stall, w_rwe, w_cwe, w_cis, w_mwe, w_mre, w_mis, w_beat};
  endfunction

  function automatic logic [8:0] ev(logic s, logic rwe, logic cwe, logic cis,
                                    logic mwe, logic mre, logic mis, int beat);
    logic [1:0] b;
    b = beat[1:0];
    return {s, rwe, cwe, cis, mwe, mre, mis, b};
  endfunction

  // mode 0: always ready, 1: ready on alternate cycles starting not-ready, 2: random
  function automatic logic draw_ready(int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) begin
      tog = ~tog;
      return tog;
    end
    return ($urandom_range(0, 2) != 0);
  endfunction

  task automatic scramble_req();
    req_valid    = 1'($urandom);
    req_is_store = 1'($urandom);
    hit          = 1'($urandom);
    dirty        = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b1;
    req_valid = 0; req_is_store = 0; hit = 0; dirty = 0; mem_ready = 0;
    s_req_valid = 0; s_hit = 0; s_zero = 0;
    w_req_valid = 0; w_is_store = 0; w_hit = 0; w_dirty = 0; w_mem_ready = 0;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    m_hits = 0; m_misses = 0; m_wbs = 0; m_replay = 0;
  endtask

  // One idle cycle on the main instance: outputs must be quiet and counters match the model.
  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 0;
    mem_ready = 1'($urandom);
    #1;
    vectors++;
    if (obs() !== 9'd0) begin
      miscompares++;
      $display("FAIL idle_outputs got=%b want=%b", obs(), 9'd0);
    end
    vectors++;
    if (hit_count !== 32'(m_hits) || miss_count !== 32'(m_misses) || wb_count !== 32'(m_wbs)) begin
      miscompares++;
      $display("FAIL counters got=%0d/%0d/%0d want=%0d/%0d/%0d",
               hit_count, miss_count, wb_count, m_hits, m_misses, m_wbs);
    end
  endtask

  // One CPU request on the main instance, followed through to completion of any miss.
  task automatic do_req(input bit store, input bit hit_i, input bit dirty_i,
                        input int mode, output int stall_cycles);
    logic r;
    logic [8:0] exp;
    tog = 1'b1;
    @(negedge clk);
    req_valid = 1; req_is_store = store; hit = hit_i; dirty = dirty_i;
    mem_ready = 1'($urandom);
    #1;
    exp = hit_i ? ev(0, !store, store, store, 0, 0, 0, 0) : ev(1, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs() !== exp) begin
      miscompares++;
      $display("FAIL lookup got=%b want=%b", obs(), exp);
    end
    stall_cycles = hit_i ? 0 : 1;
    m_replay_update : begin
      if (hit_i) begin
        if (!m_replay) m_hits++;
        m_replay = 0;
      end else begin
        m_misses++;
        if (dirty_i) m_wbs++;
        m_replay = 0;
      end
    end
    if (!hit_i) begin
      if (dirty_i) begin
        for (int k = 0; k < WPB; k++) begin
          r = 1'b0;
          while (!r) begin
            @(negedge clk);
            r = draw_ready(mode);
            mem_ready = r;
            scramble_req();
            #1;
            exp = ev(1, 0, 0, 0, 1, 0, 1, k);
            vectors++;
            if (obs() !== exp) begin
              miscompares++;
              $display("FAIL writeback beat=%0d got=%b want=%b", k, obs(), exp);
            end
            stall_cycles++;
          end
        end
      end
      for (int k = 0; k < WPB; k++) begin
        r = 1'b0;
        while (!r) begin
          @(negedge clk);
          r = draw_ready(mode);
          mem_ready = r;
          scramble_req();
          #1;
          exp = ev(1, 0, r, 0, 0, 1, 0, k);
          vectors++;
          if (obs() !== exp) begin
            miscompares++;
            $display("FAIL refill beat=%0d got=%b want=%b", k, obs(), exp);
          end
          stall_cycles++;
        end
      end
      @(negedge clk);
      mem_ready = 1'($urandom);
      scramble_req();
      #1;
      exp = ev(1, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL commit got=%b want=%b", obs(), exp);
      end
      stall_cycles++;
      m_replay = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    idle_cycle();
    vectors++;
    if (s_hit_count !== 4'd0 || s_stall !== 1'b0 || obs_w() !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_aux got=%0d/%b/%b want=0/0/0", s_hit_count, s_stall, obs_w());
    end
  endtask

  task automatic test_load_hit();
    int sc;
    do_reset();
    do_req(0, 1, 0, 0, sc);
    idle_cycle();
    vectors++;
    if (hit_count !== 32'd1) begin
      miscompares++;
      $display("FAIL load_hit_count got=%0d want=1", hit_count);
    end
  endtask

  task automatic test_clean_miss();
    int sc;
    do_reset();
    do_req(0, 0, 0, 0, sc);
    vectors++;
    if (sc !== 6) begin
      miscompares++;
      $display("FAIL clean_miss_stall got=%0d want=6", sc);
    end
    do_req(0, 1, 0, 0, sc);
    idle_cycle();
    vectors++;
    if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
      miscompares++;
      $display("FAIL clean_miss_counts got=%0d/%0d want=1/0", miss_count, hit_count);
    end
  endtask

  task automatic test_dirty_store_miss();
    int sc;
    do_reset();
    do_req(1, 0, 1, 1, sc);
    vectors++;
    if (sc !== 18) begin
      miscompares++;
      $display("FAIL dirty_miss_stall got=%0d want=18", sc);
    end
    do_req(1, 1, 0, 0, sc);
    idle_cycle();
    vectors++;
    if (wb_count !== 32'd1 || miss_count !== 32'd1 || hit_count !== 32'd0) begin
      miscompares++;
      $display("FAIL dirty_miss_counts got=%0d/%0d/%0d want=1/1/0", wb_count, miss_count, hit_count);
    end
  endtask

  task automatic test_random();
    int sc;
    bit h;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        idle_cycle();
      end else begin
        h = m_replay ? ($urandom_range(0, 6) != 0) : 1'($urandom);
        do_req(1'($urandom), h, 1'($urandom), 2, sc);
        if ($urandom_range(0, 2) == 0) idle_cycle();
      end
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid_refill();
    do_reset();
    @(negedge clk);
    req_valid = 1; req_is_store = 0; hit = 0; dirty = 0; mem_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (beat_idx !== 2'd2 || mem_re !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_refill got=beat%0d/re%b want=beat2/re1", beat_idx, mem_re);
    end
    rst_b = 1'b1;
    req_valid = 0;
    @(negedge clk);
    rst_b = 1'b0;
    m_hits = 0; m_misses = 0; m_wbs = 0; m_replay = 0;
    #1;
    vectors++;
    if (obs() !== 9'd0 || miss_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_refill got=%b/%0d want=%b/0", obs(), miss_count, 9'd0);
    end
    idle_cycle();
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    s_req_valid = 1; s_hit = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #1;
      want = (i > 15) ? 15 : i;
      vectors++;
      if (s_hit_count !== 4'(want) || s_stall !== 1'b0 || s_rwe !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_hit i=%0d got=%0d/%b/%b want=%0d/0/1", i, s_hit_count, s_stall, s_rwe, want);
      end
    end
    s_req_valid = 0;
    s_hit = 0;
  endtask

  task automatic test_single_word();
    logic [7:0] want [0:8];
    // clean miss: lookup, one refill beat, commit, replay hit; then dirty miss: lookup, wb, refill, commit
    want[0] = 8'b1000_0000;
    want[1] = 8'b1010_0100;
    want[2] = 8'b1000_0000;
    want[3] = 8'b0100_0000;
    want[4] = 8'b0000_0000;
    want[5] = 8'b1000_0000;
    want[6] = 8'b1000_1010;
    want[7] = 8'b1010_0100;
    want[8] = 8'b1000_0000;
    do_reset();
    w_mem_ready = 1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      w_req_valid = (c != 4);
      w_hit       = (c == 3);
      w_dirty     = (c == 5);
      #1;
      vectors++;
      if (obs_w() !== want[c]) begin
        miscompares++;
        $display("FAIL single_word cycle=%0d got=%b want=%b", c, obs_w(), want[c]);
      end
    end
    @(negedge clk);
    w_req_valid = 0;
    #1;
    vectors++;
    if (w_miss_count !== 32'd2 || w_hit_count !== 32'd0 || w_wb_count !== 32'd1) begin
      miscompares++;
      $display("FAIL single_word_counts got=%0d/%0d/%0d want=2/0/1", w_miss_count, w_hit_count, w_wb_count);
    end
  endtask

  initial begin
    rst_b = 1'b1;
    test_reset();
    test_load_hit();
    test_clean_miss();
    test_dirty_store_miss();
    test_random();
    test_reset_mid_refill();
    test_saturation();
    test_single_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_wb_ctrl.md
Name: cache_wb_ctrl

Overview:
Parametrised write-back cache controller FSM, successor to the single-block LW/SW cache CU. It sits between the datapath (hit/dirty from the tag array) and main memory. It replaces the fixed 4-cycle memory timing with a per-beat `mem_ready` handshake and supports a configurable number of words per block. It adds an explicit CPU stall and saturating hit/miss/writeback performance counters.

Parameters:
- WORDS_PER_BLOCK, 4, words per cache block = memory beats per writeback/refill; power of 2, >= 1.
- CNT_W, 32, width of each performance counter.
- BEAT_W (localparam), max(1, $clog2(WORDS_PER_BLOCK)), width of `beat_idx`.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_b  in  1  reset, synchronous, active-high.
- req_valid  in  1  CPU presents a load/store this cycle (datapath decodes LW/SW).
- req_is_store  in  1  1 = store, 0 = load; valid only with `req_valid`.
- hit  in  1  tag match + valid for the current address.
- dirty  in  1  victim line dirty bit.
- mem_ready  in  1  memory completes the current beat this cycle.
- stall  out  1  freeze PC/pipeline.
- reg_write_enable  out  1  load data may be written to the register file.
- cache_we  out  1  cache data/tag write strobe.
- cache_in_select  out  1  1 = CPU store data, 0 = memory read data.
- mem_we  out  1  memory write strobe (writeback beat).
- mem_re  out  1  memory read request (refill beat).
- mem_in_select  out  1  1 = victim tag address/data, 0 = requested address.
- beat_idx  out  BEAT_W  word offset of the current beat.
- hit_count  out  CNT_W  first-lookup hits.
- miss_count  out  CNT_W  first-lookup misses.
- wb_count  out  CNT_W  dirty evictions.

Behaviour:
- Reset (rst_b high at a clk edge):
  - state = IDLE, `beat_idx` = 0, replay flag = 0, all counters = 0.
  - All control outputs are 0 in IDLE with `req_valid` = 0.
  - Reset mid-operation abandons the transaction; no further strobes.
- Outputs are combinational from state + inputs (Mealy); registers are state, `beat_idx`, replay, counters.
- IDLE:
  - `req_valid` = 0: all outputs 0.
  - `req_valid` & `hit`: `stall` = 0. Load → `reg_write_enable` = 1 in the same cycle. Store → `cache_we` = 1 and `cache_in_select` = 1. Stay in IDLE; clear replay.
  - `req_valid` & !`hit`: `stall` = 1. Go to WRITEBACK if `dirty`, else REFILL; `beat_idx` ← 0.
- WRITEBACK:
  - `stall` = 1, `mem_we` = 1, `mem_in_select` = 1.
  - On `mem_ready`, `beat_idx` increments. On `mem_ready` at the last beat, go to REFILL with `beat_idx` ← 0.
  - No `mem_ready`: hold state and `beat_idx` (wait states unbounded).
- REFILL:
  - `stall` = 1, `mem_re` = 1, `mem_in_select` = 0.
  - `cache_we` = `mem_ready`, `cache_in_select` = 0, so the word at `beat_idx` is written when the beat completes.
  - `beat_idx` increments on `mem_ready`. On `mem_ready` at the last beat, go to COMMIT.
- COMMIT:
  - `stall` = 1 for exactly one cycle; set replay; go to IDLE.
  - The replayed access then hits in IDLE and completes as a normal hit.
- Counters:
  - Update only on the first IDLE evaluation of a request (replay = 0); the replayed hit is not counted.
  - `miss_count` increments on leaving IDLE; `wb_count` increments on entering WRITEBACK.
  - All counters saturate at all-ones; no wrap.
- Latency with `mem_ready` held at 1, W = WORDS_PER_BLOCK:
  - Clean miss: 1 (IDLE) + W (REFILL) + 1 (COMMIT) stall cycles, then the hit cycle.
  - Dirty miss: adds W writeback cycles.
- Boundary conditions:
  - `req_valid`, `hit`, `dirty` and `req_is_store` are ignored outside IDLE; deasserting `req_valid` mid-miss still completes the refill.
  - `mem_ready` is ignored in IDLE and COMMIT.
  - WORDS_PER_BLOCK = 1: `beat_idx` is held at 0 and every beat is the last beat.
  - A `hit` that drops after COMMIT (victim aliasing) is treated as a new miss, counted as a miss.

Decomposition:
- Package cache_pkg holds:
  - state enum (IDLE, WRITEBACK, REFILL, COMMIT);
  - the `cache_in_select`/`mem_in_select` encodings;
  - the LW/SW opcode constants shared with the datapath decoder.
- Sub-module sat_counter (parameter width; inputs clk, rst_b, inc; output count) is instantiated three times.

Test Plan (WORDS_PER_BLOCK = 4 unless stated):
- Reset held 2 cycles, then idle with `req_valid` = 0 → all control outputs 0, `beat_idx` = 0, counters 0.
- Load hit (`req_valid` = 1, `req_is_store` = 0, `hit` = 1) → same cycle `reg_write_enable` = 1, `stall` = 0, `cache_we` = 0; `hit_count` = 1 next cycle.
- Clean load miss, `mem_ready` always 1 → `stall` high 6 cycles, `cache_we` pulses 4 cycles with `beat_idx` 0,1,2,3, then hit cycle with `reg_write_enable` = 1; `miss_count` = 1, `hit_count` = 0.
- Dirty store miss, `mem_ready` on alternate cycles → 4 `mem_we` beats (`mem_in_select` = 1) over 8 cycles, then 4 refill beats over 8 cycles, `beat_idx` advancing only on ready; replay store gives `cache_we` = 1 with `cache_in_select` = 1; `wb_count` = 1.
- Reset asserted during REFILL at `beat_idx` = 2 → next cycle IDLE, all strobes 0, `beat_idx` = 0, counters 0.
- CNT_W = 4, 20 consecutive load hits → `hit_count` stops at 15; WORDS_PER_BLOCK = 1 clean miss → single REFILL beat, `beat_idx` constant 0.
